// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx
//  Purpose  : UART transmitter. Accepts a parallel word over a valid/ready
//             handshake and serialises it as a start bit, DATA_BITS data bits
//             (LSB first), an optional parity bit and STOP_BITS stop bits.
//             Bit timing comes from the shared oversample strobe i_en, with
//             OSR strobes per bit period.
//  Ports    : i_clk    - system clock, rising edge
//             i_rst    - synchronous active-high reset
//             i_en     - oversample strobe, one-cycle pulses
//             i_data   - word to send, sampled on accept
//             i_valid  - i_data valid
//             o_ready  - idle, a word can be accepted
//             o_tx     - serial line, idle high, registered
//             o_done   - one-cycle pulse when the last stop bit completes
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int OSR       = 16,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 2,
    parameter int PARITY    = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic                 o_tx,
    output logic                 o_done
);

    localparam int c_TW = $clog2(OSR);
    localparam int c_BW = $clog2(DATA_BITS);

    localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(OSR - 1);
    localparam logic [c_BW-1:0] c_DATA_LAST = c_BW'(DATA_BITS - 1);
    localparam logic [c_BW-1:0] c_STOP_LAST = c_BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 r_state_q, w_state_d;
    logic [c_TW-1:0]        r_tick_q,  w_tick_d;
    logic [c_BW-1:0]        r_bit_q,   w_bit_d;
    logic [DATA_BITS-1:0]   r_shift_q, w_shift_d;
    logic                   r_par_q,   w_par_d;
    logic                   r_tx_q,    w_tx_d;
    logic                   r_done_q,  w_done_d;

    logic                   w_par_in;
    logic                   w_bit_end;

    // Parity is taken from the word as accepted; odd parity inverts the XOR.
    assign w_par_in  = (PARITY == 1) ? ~(^i_data) : (^i_data);

    // A bit period ends on the OSR-th strobe counted since the last boundary.
    assign w_bit_end = i_en && (r_tick_q == c_TICK_LAST);

    always_comb begin
        w_state_d = r_state_q;
        w_tick_d  = r_tick_q;
        w_bit_d   = r_bit_q;
        w_shift_d = r_shift_q;
        w_par_d   = r_par_q;
        w_tx_d    = r_tx_q;
        w_done_d  = 1'b0;

        if (r_state_q != S_IDLE && i_en) begin
            w_tick_d = w_bit_end ? '0 : r_tick_q + c_TW'(1);
        end

        case (r_state_q)
            S_IDLE: begin
                w_tx_d = 1'b1;
                if (i_valid) begin
                    w_shift_d = i_data;
                    w_par_d   = w_par_in;
                    w_tick_d  = '0;
                    w_bit_d   = '0;
                    w_tx_d    = 1'b0;
                    w_state_d = S_START;
                end
            end

            S_START: begin
                if (w_bit_end) begin
                    w_tx_d    = r_shift_q[0];
                    w_bit_d   = '0;
                    w_state_d = S_DATA;
                end
            end

            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_q == c_DATA_LAST) begin
                        w_bit_d = '0;
                        if (PARITY != 0) begin
                            w_tx_d    = r_par_q;
                            w_state_d = S_PARITY;
                        end else begin
                            w_tx_d    = 1'b1;
                            w_state_d = S_STOP;
                        end
                    end else begin
                        // Present the next data bit as the shifter moves on.
                        w_shift_d = {1'b0, r_shift_q[DATA_BITS-1:1]};
                        w_tx_d    = r_shift_q[1];
                        w_bit_d   = r_bit_q + c_BW'(1);
                    end
                end
            end

            S_PARITY: begin
                if (w_bit_end) begin
                    w_tx_d    = 1'b1;
                    w_bit_d   = '0;
                    w_state_d = S_STOP;
                end
            end

            S_STOP: begin
                // The bit counter doubles as the stop-bit counter.
                if (w_bit_end) begin
                    if (r_bit_q == c_STOP_LAST) begin
                        w_bit_d   = '0;
                        w_done_d  = 1'b1;
                        w_state_d = S_IDLE;
                    end else begin
                        w_bit_d = r_bit_q + c_BW'(1);
                    end
                end
            end

            default: begin
                w_tx_d    = 1'b1;
                w_tick_d  = '0;
                w_bit_d   = '0;
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q <= S_IDLE;
            r_tick_q  <= '0;
            r_bit_q   <= '0;
            r_shift_q <= '0;
            r_par_q   <= 1'b0;
            r_tx_q    <= 1'b1;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_tick_q  <= w_tick_d;
            r_bit_q   <= w_bit_d;
            r_shift_q <= w_shift_d;
            r_par_q   <= w_par_d;
            r_tx_q    <= w_tx_d;
            r_done_q  <= w_done_d;
        end
    end

    // Ready is high in the o_done cycle too, so frames can run back to back.
    assign o_ready = (r_state_q == S_IDLE);
    assign o_tx    = r_tx_q;
    assign o_done  = r_done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx
//  Purpose  : Self-checking bench for uart_tx. Four instances with different
//             framing share clock, reset, strobe and data; each has its own
//             valid. Frames are checked bit by bit against hand-built
//             expected bit patterns (bit i = i-th bit on the line).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int c_OSR = 16;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] data_r;
    logic [3:0] valid_v;
    logic [3:0] ready_v;
    logic [3:0] tx_v;
    logic [3:0] done_v;

    int  en_period;
    int  phase;
    bit  stall;

    int  n_cmp;
    int  n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        phase <= (phase >= en_period - 1) ? 0 : phase + 1;
    end
    assign en = (phase == 0) && !stall;

    // 0: 8N2, 1: 8E2, 2: 8O2, 3: 7N1
    uart_tx #(.OSR(c_OSR), .DATA_BITS(8), .STOP_BITS(2), .PARITY(0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_data(data_r), .i_valid(valid_v[0]),
        .o_ready(ready_v[0]), .o_tx(tx_v[0]), .o_done(done_v[0]));
    uart_tx #(.OSR(c_OSR), .DATA_BITS(8), .STOP_BITS(2), .PARITY(2)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_data(data_r), .i_valid(valid_v[1]),
        .o_ready(ready_v[1]), .o_tx(tx_v[1]), .o_done(done_v[1]));
    uart_tx #(.OSR(c_OSR), .DATA_BITS(8), .STOP_BITS(2), .PARITY(1)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_data(data_r), .i_valid(valid_v[2]),
        .o_ready(ready_v[2]), .o_tx(tx_v[2]), .o_done(done_v[2]));
    uart_tx #(.OSR(c_OSR), .DATA_BITS(7), .STOP_BITS(1), .PARITY(0)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_data(data_r[6:0]), .i_valid(valid_v[3]),
        .o_ready(ready_v[3]), .o_tx(tx_v[3]), .o_done(done_v[3]));

    typedef struct {
        int         sel;
        logic [7:0] data;
        int         period;
        logic [15:0] exp;
        int         nbits;
    } vec_t;

    vec_t tbl [8];

    // Send one word on instance sel and check every cycle of the frame.
    task automatic run_frame(input int sel, input logic [7:0] d, input int p,
                             input logic [15:0] ex, input int nb, input bit hold,
                             input logic [7:0] nd, input bit chk_imm);
        int w;
        int len;
        bit ok;
        logic a_tx, a_rdy, a_done;
        en_period = p;
        len = c_OSR * p;
        w = 0;
        @(negedge clk);
        while (!(ready_v[sel] && phase == 0) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 2000) begin
            n_cmp++; n_fail++;
            $display("FAIL wait_ready dut%0d: ready never seen (got %b, want 1)", sel, ready_v[sel]);
            return;
        end
        if (chk_imm) begin
            n_cmp++;
            if (w != 0) begin
                n_fail++;
                $display("FAIL back_to_back dut%0d: idle gap %0d cycles, want 0", sel, w);
            end
        end
        data_r = d;
        valid_v[sel] = 1'b1;
        @(posedge clk); #1;
        if (!hold) valid_v[sel] = 1'b0;
        data_r = nd;
        for (int i = 0; i < nb; i++) begin
            ok = 1'b1;
            a_tx = 1'b0; a_rdy = 1'b0; a_done = 1'b0;
            for (int j = 0; j < len; j++) begin
                if (ok && (tx_v[sel] !== ex[i] || ready_v[sel] !== 1'b0 || done_v[sel] !== 1'b0)) begin
                    ok = 1'b0;
                    a_tx = tx_v[sel]; a_rdy = ready_v[sel]; a_done = done_v[sel];
                end
                @(posedge clk); #1;
            end
            n_cmp++;
            if (!ok) begin
                n_fail++;
                $display("FAIL frame dut%0d data=%h bit%0d: tx/ready/done=%b%b%b, want %b00",
                         sel, d, i, a_tx, a_rdy, a_done, ex[i]);
            end
        end
        n_cmp++;
        if (done_v[sel] !== 1'b1 || ready_v[sel] !== 1'b1 || tx_v[sel] !== 1'b1) begin
            n_fail++;
            $display("FAIL done_cycle dut%0d data=%h: tx/ready/done=%b%b%b, want 111",
                     sel, d, tx_v[sel], ready_v[sel], done_v[sel]);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        logic [6:0] v7;

        n_cmp = 0; n_fail = 0;
        rst = 1'b1; valid_v = '0; data_r = '0; stall = 1'b0; en_period = 1; phase = 0;

        tbl[0] = '{sel:0, data:8'hA5, period:1, exp:16'({2'b11, 8'hA5, 1'b0}),       nbits:11};
        tbl[1] = '{sel:0, data:8'h81, period:1, exp:16'({2'b11, 8'h81, 1'b0}),       nbits:11};
        tbl[2] = '{sel:1, data:8'h07, period:1, exp:16'({2'b11, 1'b1, 8'h07, 1'b0}), nbits:12};
        tbl[3] = '{sel:2, data:8'h07, period:1, exp:16'({2'b11, 1'b0, 8'h07, 1'b0}), nbits:12};
        tbl[4] = '{sel:1, data:8'hFF, period:1, exp:16'({2'b11, 1'b0, 8'hFF, 1'b0}), nbits:12};
        tbl[5] = '{sel:2, data:8'h00, period:1, exp:16'({2'b11, 1'b1, 8'h00, 1'b0}), nbits:12};
        tbl[6] = '{sel:0, data:8'h00, period:4, exp:16'({2'b11, 8'h00, 1'b0}),       nbits:11};
        tbl[7] = '{sel:3, data:8'h5A, period:1, exp:16'({1'b1, 7'h5A, 1'b0}),        nbits:9};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) begin
            n_cmp++;
            if (tx_v[s] !== 1'b1 || ready_v[s] !== 1'b1 || done_v[s] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: tx/ready/done=%b%b%b, want 110",
                         s, tx_v[s], ready_v[s], done_v[s]);
            end
        end
        @(negedge clk);
        rst = 1'b0;

        // Table-driven frames
        for (int k = 0; k < 8; k++) begin
            run_frame(tbl[k].sel, tbl[k].data, tbl[k].period, tbl[k].exp,
                      tbl[k].nbits, 1'b0, 8'h00, 1'b0);
        end

        // 7N1: every value
        for (int v = 0; v < 128; v++) begin
            v7 = 7'(v);
            run_frame(3, {1'b0, v7}, 1, 16'({1'b1, v7, 1'b0}), 9, 1'b0, 8'h00, 1'b0);
        end

        // Back-to-back with valid held; data changes mid-frame 1
        run_frame(0, 8'h55, 1, 16'({2'b11, 8'h55, 1'b0}), 11, 1'b1, 8'hAA, 1'b0);
        run_frame(0, 8'hAA, 1, 16'({2'b11, 8'hAA, 1'b0}), 11, 1'b0, 8'h00, 1'b1);

        // Reset during data bit 3 of an 8'hA5 frame
        en_period = 1;
        @(negedge clk);
        data_r = 8'hA5; valid_v[0] = 1'b1;
        @(posedge clk); #1;
        valid_v[0] = 1'b0;
        repeat (70) begin @(posedge clk); #1; end
        n_cmp++;
        if (tx_v[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_reset_bit3: tx=%b, want 0", tx_v[0]);
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (tx_v[0] !== 1'b1 || ready_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_frame_reset: tx/ready/done=%b%b%b, want 110",
                     tx_v[0], ready_v[0], done_v[0]);
        end
        @(negedge clk); rst = 1'b0;
        ok = 1'b1;
        repeat (200) begin
            @(posedge clk); #1;
            if (tx_v[0] !== 1'b1 || done_v[0] !== 1'b0 || ready_v[0] !== 1'b1) ok = 1'b0;
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL after_reset_idle: line/done/ready disturbed, want 1/0/1");
        end
        run_frame(0, 8'h3C, 1, 16'({2'b11, 8'h3C, 1'b0}), 11, 1'b0, 8'h00, 1'b0);

        // Stalled strobe: 100 lost strobes in data bit 0 push o_done out by 100
        en_period = 1;
        @(negedge clk);
        data_r = 8'hA5; valid_v[0] = 1'b1;
        @(posedge clk); #1;
        valid_v[0] = 1'b0;
        ok = 1'b1;
        for (int k = 0; k < 276; k++) begin
            if (done_v[0] !== 1'b0 || ready_v[0] !== 1'b0) ok = 1'b0;
            if (k >= 20 && k <= 120 && tx_v[0] !== 1'b1) ok = 1'b0;
            @(negedge clk);
            if (k == 20)  stall = 1'b1;
            if (k == 120) stall = 1'b0;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL stall_hold: bit not held or early done/ready, want held");
        end
        n_cmp++;
        if (done_v[0] !== 1'b1 || ready_v[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_done: done/ready=%b%b, want 11", done_v[0], ready_v[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
